// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;
    localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the arbiter.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [3:0]        dm_be;
    logic              dm_done;
    logic [31:0]       dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
        output if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
        input  if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters,
// data first, with an anti-starvation limit so fetch always progresses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus,
    output logic               busy,
    output logic               owner_dm
);
    localparam logic [3:0] LAT  = 4'(READ_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              if_elig, dm_elig, grant_if, grant_dm;

    // No grant at all while a done pulse is out, so a requester sees its done before re-arbitration.
    assign if_elig  = bus.if_req & ~if_done_q & ~dm_done_q;
    assign dm_elig  = bus.dm_req & ~if_done_q & ~dm_done_q;
    assign grant_dm = (state_q == IDLE) & dm_elig & ~(if_elig & (starve_q == SMAX));
    assign grant_if = (state_q == IDLE) & if_elig & ~grant_dm;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        lat_d      = lat_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        starve_d   = (!bus.if_req || grant_if) ? 4'd0 :
                     grant_dm ? ((starve_q == SMAX) ? starve_q : starve_q + 4'd1) : starve_q;
        case (state_q)
            IDLE: begin
                if (grant_dm || grant_if) begin
                    state_d  = ACCESS;
                    owner_d  = grant_dm ? OWN_DM : OWN_IF;
                    addr_d   = grant_dm ? bus.dm_addr : bus.if_addr;
                    we_d     = grant_dm & bus.dm_we;
                    wdata_d  = grant_dm ? bus.dm_wdata : wdata_q;
                    be_d     = grant_dm ? bus.dm_be : BE_WORD;
                    mem_en_d = 1'b1;
                    mem_we_d = grant_dm & bus.dm_we;
                end
            end
            ACCESS: begin
                state_d   = we_q ? IDLE : WAIT;
                lat_d     = we_q ? lat_q : LAT;
                dm_done_d = we_q & (owner_q == OWN_DM);
                if_done_d = we_q & (owner_q == OWN_IF);
            end
            WAIT: begin
                if (lat_q == 4'd1) begin
                    state_d    = IDLE;
                    dm_done_d  = owner_q == OWN_DM;
                    if_done_d  = owner_q == OWN_IF;
                    dm_rdata_d = (owner_q == OWN_DM) ? bus.mem_rdata : dm_rdata_q;
                    if_rdata_d = (owner_q == OWN_IF) ? bus.mem_rdata : if_rdata_q;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            lat_q      <= '0;
            starve_q   <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign busy          = state_q != IDLE;
    assign owner_dm      = owner_q == OWN_DM;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation and reset abort.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic a_busy, a_owner, b_busy, b_owner;
    logic [31:0] rd_a, pb0, pb1, pb2;
    int tests = 0;
    int failed = 0;
    bit grants[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) a();
    mem_port_arbiter_if #(.ADDR_W(32)) b();

    mem_port_arbiter #(.ADDR_W(32), .READ_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .reset(reset_a), .bus(a), .busy(a_busy), .owner_dm(a_owner)
    );
    mem_port_arbiter #(.ADDR_W(32), .READ_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .reset(reset_b), .bus(b), .busy(b_busy), .owner_dm(b_owner)
    );

    function automatic logic [31:0] memf(input logic [31:0] addr);
        return (addr == 32'h40) ? 32'h00500093 : (addr ^ 32'hA5A50000);
    endfunction

    // Read data is only valid exactly READ_LAT cycles after the enable cycle.
    always @(posedge clk) begin
        rd_a <= (a.mem_en && !a.mem_we) ? memf(a.mem_addr) : 32'hBAD0BAD0;
        pb0  <= (b.mem_en && !b.mem_we) ? memf(b.mem_addr) : 32'hBAD0BAD0;
        pb1  <= pb0;
        pb2  <= pb1;
        if (!reset_a && a.mem_en) grants.push_back(a_owner);
    end
    assign a.mem_rdata = rd_a;
    assign b.mem_rdata = pb2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        bit seen;
        logic g;
        bit exp_g[6] = '{1, 1, 1, 1, 0, 1};
        a.if_req = 0; a.if_addr = 0; a.dm_req = 0; a.dm_we = 0; a.dm_addr = 0; a.dm_wdata = 0; a.dm_be = 0;
        b.if_req = 0; b.if_addr = 0; b.dm_req = 0; b.dm_we = 0; b.dm_addr = 0; b.dm_wdata = 0; b.dm_be = 0;
        tick(); tick();
        reset_a = 0; reset_b = 0;
        check("rst_flags", {a.if_done, a.dm_done, a.mem_en, a.mem_we, a_busy, a_owner}, 0);
        check("rst_data", a.mem_addr | a.mem_wdata | a.if_rdata | a.dm_rdata | 32'(a.mem_be), 0);

        // fetch read, READ_LAT=1
        a.if_req = 1; a.if_addr = 32'h40;
        check("if_c0_en", a.mem_en, 0);
        tick();
        check("if_c1_ctl", {a.mem_en, a.mem_we, a.mem_be, a_busy}, 7'b1011111);
        check("if_c1_addr", a.mem_addr, 32'h40);
        tick();
        check("if_c2_done", {a.if_done, a.mem_en}, 0);
        tick();
        check("if_c3_done", a.if_done, 1);
        check("if_c3_rdata", a.if_rdata, 32'h00500093);
        tick();
        check("if_c4_pulse", {a.if_done, a.mem_en}, 0);
        a.if_req = 0;
        tick();
        check("if_c5_nodup", {a.mem_en, a_busy}, 0);

        // data store
        a.dm_req = 1; a.dm_we = 1; a.dm_addr = 32'h100; a.dm_wdata = 32'hDEADBEEF; a.dm_be = 4'b0011;
        tick();
        check("st_c1_ctl", {a.mem_en, a.mem_we, a.mem_be, a_owner}, 7'b1100111);
        check("st_c1_addr", a.mem_addr, 32'h100);
        check("st_c1_wdata", a.mem_wdata, 32'hDEADBEEF);
        tick();
        check("st_c2_done", {a.dm_done, a.if_done, a.mem_en, a.mem_we}, 4'b1000);
        a.dm_req = 0;
        tick();
        check("st_c3_pulse", a.dm_done, 0);

        // simultaneous requests: data first, fetch after the done cycle
        a.if_req = 1; a.if_addr = 32'h44;
        a.dm_req = 1; a.dm_we = 0; a.dm_addr = 32'h200; a.dm_be = 4'b1111;
        tick();
        check("both_c1", {a.mem_en, a_owner}, 2'b11);
        check("both_c1_addr", a.mem_addr, 32'h200);
        tick();
        tick();
        check("both_c3_dmdone", {a.dm_done, a.if_done}, 2'b10);
        check("both_c3_rdata", a.dm_rdata, 32'hA5A50200);
        a.dm_req = 0;
        tick();
        check("both_c4_noif", {a.mem_en, a_busy}, 0);
        tick();
        check("both_c5_if", {a.mem_en, a_owner}, 2'b10);
        check("both_c5_addr", a.mem_addr, 32'h44);
        tick();
        tick();
        check("both_c7_ifdone", a.if_done, 1);
        check("both_c7_rdata", a.if_rdata, 32'hA5A50044);
        a.if_req = 0;
        tick();

        // starvation limit: four data grants, then fetch, then data again
        grants.delete();
        a.if_req = 1; a.if_addr = 32'h48;
        a.dm_req = 1; a.dm_we = 1; a.dm_addr = 32'h104; a.dm_wdata = 32'h11111111; a.dm_be = 4'b1111;
        for (int c = 0; c < 80 && grants.size() < 6; c++) begin
            tick();
            if (a.if_done) a.if_req = 0;
        end
        check("starve_count", grants.size(), 6);
        for (int i = 0; i < 6; i++) begin
            g = (i < grants.size()) ? grants[i] : 1'bx;
            check($sformatf("starve_grant%0d", i), 32'(g), 32'(exp_g[i]));
        end
        for (int c = 0; c < 20 && !a.dm_done; c++) tick();
        check("starve_dmdone", a.dm_done, 1);
        check("starve_ifdata", a.if_rdata, 32'hA5A50048);
        a.dm_req = 0;
        tick(); tick();
        check("starve_idle", {a_busy, a.mem_en}, 0);

        // READ_LAT=3 load
        b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h300; b.dm_be = 4'b1111;
        tick();
        check("l3_c1_en", b.mem_en, 1);
        tick(); tick(); tick();
        check("l3_c4_done", b.dm_done, 0);
        tick();
        check("l3_c5_done", b.dm_done, 1);
        check("l3_c5_rdata", b.dm_rdata, 32'hA5A50300);
        b.dm_req = 0;
        tick();

        // reset during WAIT aborts the access
        b.dm_req = 1; b.dm_addr = 32'h304;
        tick(); tick(); tick();
        check("abort_c3_busy", b_busy, 1);
        reset_b = 1;
        tick();
        check("abort_flags", {b.if_done, b.dm_done, b.mem_en, b.mem_we, b_busy, b_owner}, 0);
        check("abort_data", b.mem_addr | b.dm_rdata | 32'(b.mem_be), 0);
        reset_b = 0; b.dm_req = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            seen |= b.dm_done | b.mem_en;
        end
        check("abort_no_done", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
